// File: rtl/lc3_decode_rf.sv
// ============================================================================
// Module   : lc3_decode_rf
// Purpose  : LC-3 decode stage. Accepts one instruction, reads up to two
//            source registers from a synchronous register file (1 or 2 read
//            ports, RF_LAT-cycle latency) and presents a registered decoded
//            bundle over a valid/ready handshake.
// Options  : DECODE_WB_BYPASS_EN adds a write-back bypass on the read paths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_decode_rf #(
    parameter int DATA_W   = 16,
    parameter int RD_PORTS = 2,
    parameter int RF_LAT   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [DATA_W-1:0] in_npc,
    output logic [2:0]        rf_addr_a,
    input  logic [DATA_W-1:0] rf_data_a,
    output logic [2:0]        rf_addr_b,
    input  logic [DATA_W-1:0] rf_data_b,
`ifdef DECODE_WB_BYPASS_EN
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [2:0]        out_dr,
    output logic [DATA_W-1:0] out_src1,
    output logic [DATA_W-1:0] out_src2,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_use_imm,
    output logic [2:0]        out_nzp,
    output logic [DATA_W-1:0] out_npc,
    output logic              out_illegal
);

    localparam int CNT_W = (RF_LAT > 1) ? $clog2(RF_LAT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(RF_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ1 = 2'd1,
        S_READ2 = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_need2;
    logic [2:0]        r_a2;
    logic [2:0]        r_addr_a;
    logic [2:0]        r_addr_b;
    logic              r_valid;
    logic [3:0]        r_op;
    logic [2:0]        r_dr;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic [DATA_W-1:0] r_imm;
    logic              r_use_imm;
    logic [DATA_W-1:0] r_npc;
    logic              r_illegal;

    logic              w_need1;
    logic              w_need2;
    logic [2:0]        w_a1;
    logic [2:0]        w_a2;
    logic [DATA_W-1:0] w_imm;
    logic              w_use_imm;
    logic              w_illegal;
    logic [DATA_W-1:0] w_samp_a;
    logic [DATA_W-1:0] w_samp_b;

    // Decode source needs, register addresses and immediate from the raw word
    always_comb begin
        w_need1   = 1'b0;
        w_need2   = 1'b0;
        w_a1      = in_instr[8:6];
        w_a2      = in_instr[2:0];
        w_imm     = '0;
        w_use_imm = 1'b0;
        w_illegal = 1'b0;
        case (in_instr[15:12])
            4'b0001, 4'b0101: begin
                w_need1   = 1'b1;
                w_need2   = ~in_instr[5];
                w_use_imm = in_instr[5];
                w_imm     = {{(DATA_W-5){in_instr[4]}}, in_instr[4:0]};
            end
            4'b1001, 4'b1100: begin
                w_need1 = 1'b1;
            end
            4'b0110: begin
                w_need1 = 1'b1;
                w_imm   = {{(DATA_W-6){in_instr[5]}}, in_instr[5:0]};
            end
            4'b0011: begin
                w_need1 = 1'b1;
                w_a1    = in_instr[11:9];
                w_imm   = {{(DATA_W-9){in_instr[8]}}, in_instr[8:0]};
            end
            4'b0111: begin
                w_need1 = 1'b1;
                w_need2 = 1'b1;
                w_a2    = in_instr[11:9];
                w_imm   = {{(DATA_W-6){in_instr[5]}}, in_instr[5:0]};
            end
            4'b0000, 4'b0010, 4'b1110: begin
                w_imm = {{(DATA_W-9){in_instr[8]}}, in_instr[8:0]};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

`ifdef DECODE_WB_BYPASS_EN
    // A write-back to the register being sampled wins over stale RF data
    assign w_samp_a = (wb_en && (wb_addr == r_addr_a)) ? wb_data : rf_data_a;
    assign w_samp_b = (wb_en && (wb_addr == r_addr_b)) ? wb_data : rf_data_b;
`else
    assign w_samp_a = rf_data_a;
    assign w_samp_b = rf_data_b;
`endif

    // Control FSM: accept, read operands with latency count, hold bundle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_need2   <= 1'b0;
            r_a2      <= 3'd0;
            r_addr_a  <= 3'd0;
            r_addr_b  <= 3'd0;
            r_valid   <= 1'b0;
            r_op      <= 4'd0;
            r_dr      <= 3'd0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_imm     <= '0;
            r_use_imm <= 1'b0;
            r_npc     <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op      <= in_instr[15:12];
                        r_dr      <= in_instr[11:9];
                        r_imm     <= w_imm;
                        r_use_imm <= w_use_imm;
                        r_illegal <= w_illegal;
                        r_npc     <= in_npc;
                        r_src1    <= '0;
                        r_src2    <= '0;
                        r_need2   <= w_need2;
                        r_a2      <= w_a2;
                        r_cnt     <= '0;
                        if (w_need1) begin
                            r_state  <= S_READ1;
                            r_addr_a <= w_a1;
                            if (RD_PORTS == 2 && w_need2)
                                r_addr_b <= w_a2;
                        end else begin
                            r_state <= S_OUT;
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_READ1: begin
                    if (r_cnt != c_CNT_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt  <= '0;
                        r_src1 <= w_samp_a;
                        if (RD_PORTS == 1 && r_need2) begin
                            // Single port: reuse port A for the second source
                            r_state  <= S_READ2;
                            r_addr_a <= r_a2;
                        end else begin
                            if (RD_PORTS == 2 && r_need2)
                                r_src2 <= w_samp_b;
                            r_addr_a <= 3'd0;
                            r_addr_b <= 3'd0;
                            r_state  <= S_OUT;
                            r_valid  <= 1'b1;
                        end
                    end
                end
                S_READ2: begin
                    if (r_cnt != c_CNT_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt    <= '0;
                        r_src2   <= w_samp_a;
                        r_addr_a <= 3'd0;
                        r_state  <= S_OUT;
                        r_valid  <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE) && !reset;
    assign rf_addr_a   = r_addr_a;
    assign rf_addr_b   = r_addr_b;
    assign out_valid   = r_valid;
    assign out_op      = r_op;
    assign out_dr      = r_dr;
    assign out_nzp     = r_dr;
    assign out_src1    = r_src1;
    assign out_src2    = r_src2;
    assign out_imm     = r_imm;
    assign out_use_imm = r_use_imm;
    assign out_npc     = r_npc;
    assign out_illegal = r_illegal;

endmodule

`default_nettype wire
